// File: rtl/sram_sample_reader_pkg.sv
// Shared widths, bank depth and reader FSM states for the SRAM sample reader.
// Pure declarations; no latency or backpressure of its own.
package sram_sample_reader_pkg;
   localparam int DW    = 32;
   localparam int AW    = 9;
   localparam int DEPTH = 512;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } state_t;
endpackage

// File: rtl/sram_sample_reader_if.sv
// Output sample stream: valid/ready handshake carrying data, last-of-bank and bank index.
// No storage; the master holds dat/last/bank stable while valid is high and ready is low.
interface sram_sample_reader_if #(
   parameter int DW = sram_sample_reader_pkg::DW
);
   logic [DW-1:0] dat_o;
   logic          valid_o;
   logic          ready_i;
   logic          last_o;
   logic          bank_o;

   modport master (output dat_o, output valid_o, output last_o, output bank_o, input ready_i);
   modport slave  (input dat_o, input valid_o, input last_o, input bank_o, output ready_i);
endinterface

// File: rtl/sram_sample_reader_skid_fifo.sv
// Two-entry output FIFO with valid/ready on both sides; head visible the cycle after a push.
// in_rdy drops only when both entries are full; flush empties it synchronously.
module sample_skid_fifo #(
   parameter int W = 34
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         push, pop;

   assign in_rdy  = (cnt_q != 2'd2);
   assign out_vld = (cnt_q != 2'd0);
   assign out_dat = mem_q[rd_ptr_q];
   assign push    = in_vld & in_rdy;
   assign pop     = out_vld & out_rdy;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/sram_sample_reader.sv
// Ping-pong drainer of two SRAM banks; first word 2 cycles after READ entry, then one per cycle.
// Reads are throttled to free FIFO space so no returned word is lost under any ready_i pattern.
module sram_sample_reader
   import sram_sample_reader_pkg::*;
#(
   parameter int DW = sram_sample_reader_pkg::DW,
   parameter int AW = sram_sample_reader_pkg::AW
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 enable_i,
   input  logic [AW:0]          len_i,
   input  logic [1:0]           bank_full_i,
   output logic [1:0]           bank_done_o,
   output logic [1:0]           mem_renb_o,
   output logic [AW-1:0]        mem_raddr_o,
   input  logic [DW-1:0]        mem0_data_i,
   input  logic [DW-1:0]        mem1_data_i,
   sram_sample_reader_if.master strm
);
   localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic          cur_bank_q, cur_bank_d;
   logic [AW:0]   addr_q, addr_d;
   logic [AW:0]   len_q, len_d;
   logic          rd_vld_q, rd_vld_d;
   logic          rd_last_q, rd_last_d;

   logic          issue, pop, fifo_flush;
   logic          fifo_in_rdy, fifo_out_vld;
   logic [1:0]    fifo_level, free;
   logic [DW+1:0] fifo_in_dat, fifo_out_dat;
   logic [AW:0]   last_addr;

   assign fifo_in_dat  = {cur_bank_q, rd_last_q, (cur_bank_q ? mem1_data_i : mem0_data_i)};
   assign strm.valid_o = fifo_out_vld;
   assign strm.bank_o  = fifo_out_dat[DW+1];
   assign strm.last_o  = fifo_out_dat[DW];
   assign strm.dat_o   = fifo_out_dat[DW-1:0];
   assign pop          = fifo_out_vld & strm.ready_i;
   assign fifo_level   = {~fifo_in_rdy, fifo_in_rdy & fifo_out_vld};
   // A word leaving this cycle frees its slot before the read issued now can land.
   assign free         = 2'd2 - fifo_level + {1'b0, pop};
   assign last_addr    = len_q - ONE;
   assign mem_raddr_o  = addr_q[AW-1:0];
   assign mem_renb_o   = issue ? (cur_bank_q ? 2'b01 : 2'b10) : 2'b11;

   always_comb begin
      state_d     = state_q;
      cur_bank_d  = cur_bank_q;
      addr_d      = addr_q;
      len_d       = len_q;
      rd_vld_d    = 1'b0;
      rd_last_d   = 1'b0;
      issue       = 1'b0;
      fifo_flush  = 1'b0;
      bank_done_o = 2'b00;
      if (!enable_i) begin
         state_d    = IDLE;
         fifo_flush = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bank_full_i[cur_bank_q]) begin
                  state_d = READ;
                  addr_d  = '0;
                  len_d   = ((len_i == '0) || (len_i > MAX_LEN)) ? MAX_LEN : len_i;
               end
            end
            READ: begin
               if (free > {1'b0, rd_vld_q}) begin
                  issue     = 1'b1;
                  rd_vld_d  = 1'b1;
                  rd_last_d = (addr_q == last_addr);
                  addr_d    = addr_q + ONE;
                  if (addr_q == last_addr) begin
                     state_d = FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (pop && fifo_out_dat[DW]) begin
                  bank_done_o[cur_bank_q] = 1'b1;
                  cur_bank_d              = ~cur_bank_q;
                  state_d                 = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         cur_bank_q <= 1'b0;
         addr_q     <= '0;
         len_q      <= MAX_LEN;
         rd_vld_q   <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_bank_q <= cur_bank_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         rd_vld_q   <= rd_vld_d;
         rd_last_q  <= rd_last_d;
      end
   end

   sample_skid_fifo #(.W(DW + 2)) u_fifo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .flush   (fifo_flush),
      .in_vld  (rd_vld_q),
      .in_rdy  (fifo_in_rdy),
      .in_dat  (fifo_in_dat),
      .out_vld (fifo_out_vld),
      .out_rdy (strm.ready_i),
      .out_dat (fifo_out_dat)
   );
endmodule
